// File: rtl/debug_ocimem_arbiter_pkg.sv
// Shared types and default widths for the OCI RAM arbiter.
package debug_ocimem_pkg;

  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_RD_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic {
    GNT_AV   = 1'b0,
    GNT_JTAG = 1'b1
  } grant_e;

endpackage

// File: rtl/debug_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the Avalon debug slave and the
// JTAG command path; round-robin on contention, auto-incrementing JTAG pointer.
module debug_ocimem_arbiter
  import debug_ocimem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   av_address,
  input  logic                av_read,
  input  logic                av_write,
  input  logic [DATA_W-1:0]   av_writedata,
  input  logic [DATA_W/8-1:0] av_byteenable,
  output logic                av_waitrequest,
  output logic [DATA_W-1:0]   av_readdata,
  input  logic                jtag_addr_load,
  input  logic [ADDR_W-1:0]   jtag_addr,
  input  logic                jtag_req,
  input  logic                jtag_wr,
  input  logic [DATA_W-1:0]   jtag_wdata,
  input  logic                jtag_err_clr,
  output logic                jtag_busy,
  output logic                jtag_done,
  output logic [DATA_W-1:0]   jtag_rdata,
  output logic                jtag_err,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_be,
  output logic                ram_rd,
  output logic                ram_wr,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int BE_W   = DATA_W / 8;
  localparam int WAIT_W = 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(RD_LATENCY - 1);

  state_e              state_r;
  grant_e              gnt_r;
  grant_e              last_gnt_r;
  logic                is_wr_r;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic                jtag_pending_r;
  logic                jtag_wr_r;
  logic [DATA_W-1:0]   jtag_wdata_r;
  logic [ADDR_W-1:0]   jtag_ptr_r;

  logic av_req_s;
  logic pick_jtag_s;
  logic jtag_fault_s;
  logic enter_done_s;
  logic done_jtag_s;

  assign av_req_s     = av_read | av_write;
  // On a tie the requester that was not served last wins.
  assign pick_jtag_s  = jtag_pending_r & (~av_req_s | (last_gnt_r == GNT_AV));
  assign jtag_fault_s = jtag_pending_r & (jtag_req | jtag_addr_load);
  assign enter_done_s = ((state_r == ACCESS) && is_wr_r) ||
                        ((state_r == WAIT) && (wait_cnt_r == {WAIT_W{1'b0}}));
  assign done_jtag_s  = (state_r == DONE) && (gnt_r == GNT_JTAG);
  assign jtag_busy    = jtag_pending_r;

  // JTAG front end: pointer, pending request capture and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jtag_pending_r <= 1'b0;
      jtag_wr_r      <= 1'b0;
      jtag_wdata_r   <= {DATA_W{1'b0}};
      jtag_ptr_r     <= {ADDR_W{1'b0}};
      jtag_err       <= 1'b0;
    end else begin
      if (jtag_fault_s) begin
        jtag_err <= 1'b1;
      end else if (jtag_err_clr) begin
        jtag_err <= 1'b0;
      end
      if (done_jtag_s) begin
        jtag_pending_r <= 1'b0;
        jtag_ptr_r     <= jtag_ptr_r + ADDR_W'(1);
      end else if (!jtag_pending_r) begin
        // A load in the same cycle as a request is applied before it is served.
        if (jtag_addr_load) begin
          jtag_ptr_r <= jtag_addr;
        end
        if (jtag_req) begin
          jtag_pending_r <= 1'b1;
          jtag_wr_r      <= jtag_wr;
          jtag_wdata_r   <= jtag_wdata;
        end
      end
    end
  end

  // Access sequencer with registered RAM strobes and completion outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      gnt_r          <= GNT_AV;
      last_gnt_r     <= GNT_JTAG;
      is_wr_r        <= 1'b0;
      wait_cnt_r     <= {WAIT_W{1'b0}};
      av_waitrequest <= 1'b1;
      av_readdata    <= {DATA_W{1'b0}};
      jtag_rdata     <= {DATA_W{1'b0}};
      jtag_done      <= 1'b0;
      ram_addr       <= {ADDR_W{1'b0}};
      ram_wdata      <= {DATA_W{1'b0}};
      ram_be         <= {BE_W{1'b0}};
      ram_rd         <= 1'b0;
      ram_wr         <= 1'b0;
    end else begin
      ram_rd         <= 1'b0;
      ram_wr         <= 1'b0;
      av_waitrequest <= ~(enter_done_s && (gnt_r == GNT_AV));
      jtag_done      <= enter_done_s && (gnt_r == GNT_JTAG);
      case (state_r)
        IDLE: begin
          if (av_req_s || jtag_pending_r) begin
            state_r <= ACCESS;
            if (pick_jtag_s) begin
              gnt_r     <= GNT_JTAG;
              is_wr_r   <= jtag_wr_r;
              ram_addr  <= jtag_ptr_r;
              ram_wdata <= jtag_wdata_r;
              ram_be    <= {BE_W{1'b1}};
              ram_wr    <= jtag_wr_r;
              ram_rd    <= ~jtag_wr_r;
            end else begin
              gnt_r     <= GNT_AV;
              is_wr_r   <= av_write;
              ram_addr  <= av_address;
              ram_wdata <= av_writedata;
              ram_be    <= av_byteenable;
              ram_wr    <= av_write;
              ram_rd    <= ~av_write;
            end
          end
        end
        ACCESS: begin
          if (is_wr_r) begin
            state_r <= DONE;
          end else begin
            state_r    <= WAIT;
            wait_cnt_r <= WAIT_INIT;
          end
        end
        WAIT: begin
          if (wait_cnt_r == {WAIT_W{1'b0}}) begin
            state_r <= DONE;
            if (gnt_r == GNT_AV) begin
              av_readdata <= ram_rdata;
            end else begin
              jtag_rdata <= ram_rdata;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r - 1'b1;
          end
        end
        DONE: begin
          state_r    <= IDLE;
          last_gnt_r <= gnt_r;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_ocimem_arbiter.sv
// Directed bench for debug_ocimem_arbiter: RAM-access and completion scoreboards
// plus inline latency/status checks.
module tb_debug_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  av_address = 8'h00;
  logic        av_read = 1'b0;
  logic        av_write = 1'b0;
  logic [31:0] av_writedata = 32'h0;
  logic [3:0]  av_byteenable = 4'hF;
  logic        av_waitrequest;
  logic [31:0] av_readdata;
  logic        jtag_addr_load = 1'b0;
  logic [7:0]  jtag_addr = 8'h00;
  logic        jtag_req = 1'b0;
  logic        jtag_wr = 1'b0;
  logic [31:0] jtag_wdata = 32'h0;
  logic        jtag_err_clr = 1'b0;
  logic        jtag_busy;
  logic        jtag_done;
  logic [31:0] jtag_rdata;
  logic        jtag_err;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic        ram_rd;
  logic        ram_wr;
  logic [31:0] ram_rdata;

  debug_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_byteenable(av_byteenable),
    .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
    .jtag_addr_load(jtag_addr_load), .jtag_addr(jtag_addr), .jtag_req(jtag_req),
    .jtag_wr(jtag_wr), .jtag_wdata(jtag_wdata), .jtag_err_clr(jtag_err_clr),
    .jtag_busy(jtag_busy), .jtag_done(jtag_done), .jtag_rdata(jtag_rdata),
    .jtag_err(jtag_err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic wr; logic [7:0] addr; logic [31:0] wdata; logic [3:0] be;} acc_t;
  typedef struct packed {logic jt; logic rd; logic [31:0] data;} cmp_t;

  acc_t acc_q[$];
  cmp_t cmp_q[$];
  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;

  // Single-port RAM, one-cycle read; preloaded with 0xC0DE00xx while in reset.
  logic [31:0] mem [256];
  logic [31:0] rd_q;
  assign ram_rdata = rd_q;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
      rd_q <= 32'h0;
    end else begin
      if (ram_wr)
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      if (ram_rd) rd_q <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: compare every RAM access and every completion in order.
  always @(negedge clk) begin
    if (!reset) begin
      if (ram_rd || ram_wr) begin
        check("acc_expected", 32'(acc_q.size() != 0), 32'd1);
        if (acc_q.size() != 0) begin
          acc_t e;
          e = acc_q.pop_front();
          check("acc_kind", {30'h0, ram_wr, ram_rd}, {30'h0, e.wr, ~e.wr});
          check("acc_addr", 32'(ram_addr), 32'(e.addr));
          if (e.wr) begin
            check("acc_wdata", ram_wdata, e.wdata);
            check("acc_be", 32'(ram_be), 32'(e.be));
          end
        end
      end
      if (!av_waitrequest || jtag_done) begin
        check("cmp_expected", 32'(cmp_q.size() != 0), 32'd1);
        if (cmp_q.size() != 0) begin
          cmp_t c;
          c = cmp_q.pop_front();
          check("cmp_src", 32'(jtag_done), 32'(c.jt));
          if (c.rd) check(c.jt ? "jt_rdata" : "av_rdata", c.jt ? jtag_rdata : av_readdata, c.data);
        end
      end
      if (jtag_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_acc(input logic wr, input logic [7:0] addr, input logic [31:0] wdata);
    acc_t a;
    a.wr = wr; a.addr = addr; a.wdata = wdata; a.be = 4'hF;
    acc_q.push_back(a);
  endtask

  task automatic push_cmp(input logic jt, input logic rd, input logic [31:0] data);
    cmp_t c;
    c.jt = jt; c.rd = rd; c.data = data;
    cmp_q.push_back(c);
  endtask

  task automatic av_wait(input int exp_lat, input string tag);
    int n = 0;
    do begin tick(); n++; end while (av_waitrequest && n < 20);
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic av_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input int exp_lat, input string tag);
    int n = 0;
    push_acc(wr, addr, wdata);
    push_cmp(1'b0, ~wr, exp_rdata);
    av_address = addr; av_write = wr; av_read = ~wr; av_writedata = wdata;
    do begin
      tick(); n++;
      if (n == 1) check({tag, "_strobe"}, {30'h0, ram_wr, ram_rd}, {30'h0, wr, ~wr});
    end while (av_waitrequest && n < 20);
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    av_read = 1'b0; av_write = 1'b0;
    tick();
  endtask

  task automatic jtag_cmd(input logic load, input logic [7:0] addr, input logic req,
                          input logic wr, input logic [31:0] wdata, input logic clr);
    jtag_addr_load = load; jtag_addr = addr; jtag_req = req;
    jtag_wr = wr; jtag_wdata = wdata; jtag_err_clr = clr;
    tick();
    jtag_addr_load = 1'b0; jtag_req = 1'b0; jtag_err_clr = 1'b0;
  endtask

  task automatic jtag_wait(input int exp_lat, input string tag);
    int n = 0;
    do begin tick(); n++; end while (!jtag_done && n < 20);
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int d0;
    tick(); tick();
    check("rst_waitreq", 32'(av_waitrequest), 32'd1);
    check("rst_flags", {27'h0, ram_rd, ram_wr, jtag_busy, jtag_done, jtag_err}, 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_av_rdata", av_readdata, 32'd0);
    check("rst_jt_rdata", jtag_rdata, 32'd0);
    reset = 1'b0;
    tick();

    // Avalon write then read-back.
    av_xfer(1'b1, 8'h10, 32'hDEAD_BEEF, 32'h0, 2, "av_wr");
    av_xfer(1'b0, 8'h10, 32'h0, 32'hDEAD_BEEF, 3, "av_rd");

    // JTAG pointer load to 0xFF then two reads wrapping to 0x00.
    jtag_cmd(1'b1, 8'hFF, 1'b0, 1'b0, 32'h0, 1'b0);
    check("load_not_busy", 32'(jtag_busy), 32'd0);
    push_acc(1'b0, 8'hFF, 32'h0); push_cmp(1'b1, 1'b1, 32'hC0DE_00FF);
    jtag_cmd(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0);
    check("jt_busy", 32'(jtag_busy), 32'd1);
    jtag_wait(3, "jt_rd_ff");
    tick();
    check("jt_done_pulse", 32'(jtag_done), 32'd0);
    check("jt_rdata_hold", jtag_rdata, 32'hC0DE_00FF);
    check("jt_idle_busy", 32'(jtag_busy), 32'd0);
    push_acc(1'b0, 8'h00, 32'h0); push_cmp(1'b1, 1'b1, 32'hC0DE_0000);
    jtag_cmd(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0);
    jtag_wait(3, "jt_rd_wrap");
    tick();
    check("jt_done_count", 32'(done_cnt), 32'd2);

    // Contention after reset: AV, then JTAG, then AV again.
    do_reset();
    push_acc(1'b0, 8'h30, 32'h0); push_acc(1'b0, 8'h00, 32'h0); push_acc(1'b0, 8'h31, 32'h0);
    push_cmp(1'b0, 1'b1, 32'hC0DE_0030); push_cmp(1'b1, 1'b1, 32'hC0DE_0000);
    push_cmp(1'b0, 1'b1, 32'hC0DE_0031);
    jtag_cmd(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0);
    av_address = 8'h30; av_read = 1'b1;
    av_wait(3, "tie1_av");
    av_address = 8'h31;
    av_wait(8, "tie2_av");
    av_read = 1'b0;
    tick();

    // Duplicate request while pending is dropped and flagged.
    d0 = done_cnt;
    push_acc(1'b0, 8'h01, 32'h0); push_cmp(1'b1, 1'b1, 32'hC0DE_0001);
    jtag_cmd(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0);
    jtag_cmd(1'b0, 8'h00, 1'b1, 1'b1, 32'h5555_5555, 1'b0);
    check("err_set", 32'(jtag_err), 32'd1);
    check("err_busy", 32'(jtag_busy), 32'd1);
    jtag_wait(2, "jt_err_rd");
    tick(); tick(); tick(); tick();
    check("err_one_done", 32'(done_cnt - d0), 32'd1);
    check("err_sticky", 32'(jtag_err), 32'd1);
    jtag_cmd(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1);
    check("err_clr", 32'(jtag_err), 32'd0);

    // Load while pending is ignored; a new error beats a same-cycle clear.
    push_acc(1'b0, 8'h02, 32'h0); push_cmp(1'b1, 1'b1, 32'hC0DE_0002);
    jtag_cmd(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0);
    jtag_cmd(1'b1, 8'h80, 1'b0, 1'b0, 32'h0, 1'b1);
    check("err_wins", 32'(jtag_err), 32'd1);
    jtag_wait(2, "jt_rd_02");
    tick();
    push_acc(1'b0, 8'h03, 32'h0); push_cmp(1'b1, 1'b1, 32'hC0DE_0003);
    jtag_cmd(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b1);
    jtag_wait(3, "jt_rd_03");
    tick();

    // Same-cycle load and write: write lands at the new address, pointer advances.
    push_acc(1'b1, 8'h20, 32'h1234_5678); push_cmp(1'b1, 1'b0, 32'h0);
    jtag_cmd(1'b1, 8'h20, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
    jtag_wait(2, "jt_wr_20");
    tick();
    push_acc(1'b0, 8'h21, 32'h0); push_cmp(1'b1, 1'b1, 32'hC0DE_0021);
    jtag_cmd(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0);
    jtag_wait(3, "jt_rd_21");
    tick();
    av_xfer(1'b0, 8'h20, 32'h0, 32'h1234_5678, 3, "av_rd_20");

    // Asynchronous reset while a read waits for data.
    push_acc(1'b0, 8'h10, 32'h0);
    av_address = 8'h10; av_read = 1'b1;
    tick(); tick();
    reset = 1'b1;
    #1;
    check("arst_ram_rd", 32'(ram_rd), 32'd0);
    check("arst_waitreq", 32'(av_waitrequest), 32'd1);
    check("arst_busy", 32'(jtag_busy), 32'd0);
    av_read = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_waitreq", 32'(av_waitrequest), 32'd1);
    av_xfer(1'b1, 8'h40, 32'hA5A5_5A5A, 32'h0, 2, "av_wr_post_rst");

    tick(); tick(); tick();
    check("acc_q_drained", 32'(acc_q.size()), 32'd0);
    check("cmp_q_drained", 32'(cmp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
